// File: rtl/mdu_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
// The package holds op codes, FSM states, the operand width and the iteration count.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITERS = 32;

  localparam logic [2:0] MDU_MULTU = 3'b000;
  localparam logic [2:0] MDU_MULT  = 3'b001;
  localparam logic [2:0] MDU_DIVU  = 3'b010;
  localparam logic [2:0] MDU_DIV   = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  // Magnitude of a two's-complement value, applied only for signed ops.
  function automatic logic [MDU_WIDTH-1:0] mag(input logic [MDU_WIDTH-1:0] v,
                                               input logic signed_op);
    return (signed_op && v[MDU_WIDTH-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the shared datapath: a shift-add step for multiply
// (LSB first) or a restoring shift-subtract step for divide (MSB first).
module mdu_step #(
  parameter int W = 32
) (
  input  logic         is_div,
  input  logic [W-1:0] acc,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] operand,
  output logic [W-1:0] acc_next,
  output logic [W-1:0] lo_next
);

  logic [W:0] sum;
  logic [W:0] rem_sh;
  logic [W:0] diff;

  always_comb begin
    sum      = '0;
    rem_sh   = '0;
    diff     = '0;
    acc_next = acc;
    lo_next  = lo;
    if (is_div) begin
      rem_sh = {acc, lo[W-1]};
      diff   = rem_sh - {1'b0, operand};
      // Remainder < divisor keeps the difference in range, so bit W is the borrow.
      acc_next = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
      lo_next  = {lo[W-2:0], ~diff[W]};
    end else begin
      sum      = {1'b0, acc} + (lo[0] ? {1'b0, operand} : '0);
      acc_next = sum[W:1];
      lo_next  = {sum[0], lo[W-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO registers.
// One datapath step per cycle; signs are stripped on entry and restored in FIX.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(MDU_ITERS);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] w_hi, w_lo, opnd;
  logic             is_div, neg_q, neg_r, dbz;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  mdu_step #(.W(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (w_hi),
    .lo       (w_lo),
    .operand  (opnd),
    .acc_next (step_hi),
    .lo_next  (step_lo)
  );

  assign prod_fix = neg_q ? -{w_hi, w_lo} : {w_hi, w_lo};
  assign quo_fix  = neg_q ? -w_lo : w_lo;
  assign rem_fix  = neg_r ? -w_hi : w_hi;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      count  <= '0;
      w_hi   <= '0;
      w_lo   <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dbz    <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !cancel) begin
            case (op)
              MDU_MULTU, MDU_MULT: begin
                state  <= S_RUN;
                count  <= CW'(MDU_ITERS - 1);
                is_div <= 1'b0;
                w_hi   <= '0;
                w_lo   <= mag(b, op[0]);
                opnd   <= mag(a, op[0]);
                neg_q  <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= 1'b0;
                dbz    <= 1'b0;
              end
              MDU_DIVU, MDU_DIV: begin
                state  <= S_RUN;
                count  <= CW'(MDU_ITERS - 1);
                is_div <= 1'b1;
                w_hi   <= '0;
                w_lo   <= mag(a, op[0]);
                opnd   <= mag(b, op[0]);
                neg_q  <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r  <= op[0] & a[WIDTH-1];
                dbz    <= (b == '0);
              end
              MDU_MTHI: begin
                hi   <= a;
                done <= 1'b1;
              end
              MDU_MTLO: begin
                lo   <= a;
                done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (cancel) begin
            state <= S_IDLE;
          end else begin
            w_hi  <= step_hi;
            w_lo  <= step_lo;
            count <= count - 1'b1;
            if (count == '0) state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!cancel) begin
            done <= 1'b1;
            if (is_div) begin
              // A zero divisor leaves |a| in the remainder, so the sign fix already yields a.
              lo <= dbz ? '1 : quo_fix;
              hi <= rem_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter with hand-computed results.
module tb_mdu_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  mdu_iter #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one MUL/DIV op, optionally poke a stray start mid-RUN, and check result and timing.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                        input bit inject);
    int cyc;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = 32'h0; b = 32'h0;
    chk({tag, " busy_after_accept"}, {31'b0, busy}, 32'd1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (inject && cyc == 5) begin
        start = 1'b1; op = 3'b000; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(cyc), 32'd33);
    chk({tag, " busy_at_done"}, {31'b0, busy}, 32'd0);
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, {31'b0, done}, 32'd0);
    $display("[TB] %s op=%0d a=%h b=%h -> hi=%h lo=%h cycles=%0d", tag, o, av, bv, hi, lo, cyc);
  endtask

  initial begin
    int seen_done;
    int seen_busy;
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'b000; a = 32'h0; b = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;

    run_op("multu_max", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mult_neg",  3'b001, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    run_op("div_neg",   3'b011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_ovf",   3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op("divu_zero", 3'b010, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b0);
    run_op("div_zero",  3'b011, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);
    run_op("divu_rem",  3'b010, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
    run_op("mult_inj",  3'b001, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1);

    // Cancel in RUN: the op vanishes, HI/LO keep the previous result.
    @(negedge clk);
    start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel busy", {31'b0, busy}, 32'd0);
    chk("cancel hi", hi, 32'hFFFFFFFF);
    chk("cancel lo", lo, 32'hFFFFFFEB);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen_done++;
      @(negedge clk);
    end
    chk("cancel no_done", 32'(seen_done), 32'd0);
    $display("[TB] cancel_run hi=%h lo=%h", hi, lo);

    // Cancel in IDLE suppresses a simultaneous start.
    start = 1'b1; cancel = 1'b1; op = 3'b000; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("idle_cancel busy", {31'b0, busy}, 32'd0);
    chk("idle_cancel done", {31'b0, done}, 32'd0);
    $display("[TB] cancel_idle busy=%b done=%b", busy, done);

    // No-op code is ignored.
    start = 1'b1; op = 3'b110; a = 32'h55555555;
    @(negedge clk);
    start = 1'b0;
    chk("noop busy", {31'b0, busy}, 32'd0);
    chk("noop done", {31'b0, done}, 32'd0);
    chk("noop hi", hi, 32'hFFFFFFFF);
    $display("[TB] noop busy=%b done=%b hi=%h", busy, done, hi);

    // MTLO then MTHI: single-edge writes with a done pulse and no busy.
    start = 1'b1; op = 3'b101; a = 32'h0BADF00D;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo lo", lo, 32'h0BADF00D);
    chk("mtlo hi_kept", hi, 32'hFFFFFFFF);
    chk("mtlo done", {31'b0, done}, 32'd1);
    chk("mtlo busy", {31'b0, busy}, 32'd0);
    $display("[TB] mtlo lo=%h done=%b", lo, done);
    start = 1'b1; op = 3'b100; a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    chk("mthi hi", hi, 32'hDEADBEEF);
    chk("mthi lo_kept", lo, 32'h0BADF00D);
    chk("mthi done", {31'b0, done}, 32'd1);
    chk("mthi busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("mthi done_one_cycle", {31'b0, done}, 32'd0);
    $display("[TB] mthi hi=%h", hi);

    // Asynchronous reset mid-MULTU clears everything immediately.
    start = 1'b1; op = 3'b000; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid hi", hi, 32'h0);
    chk("rst_mid lo", lo, 32'h0);
    chk("rst_mid busy", {31'b0, busy}, 32'd0);
    chk("rst_mid done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_busy = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen_busy++;
      @(negedge clk);
    end
    chk("rst_mid stays_idle", 32'(seen_busy), 32'd0);
    $display("[TB] reset_mid hi=%h lo=%h busy=%b", hi, lo, busy);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
